// File: rtl/hls_call_sequencer.sv
// Call sequencer for an HLS callee: queues argument words, runs one call at a
// time on the start/done handshake and returns each result (or a timeout) on a ready/valid port.
module hls_call_sequencer #(
  parameter int ARG_W   = 1,
  parameter int RES_W   = 2,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ARG_W-1:0] in_arg,
  output logic             call_start,
  output logic [ARG_W-1:0] call_arg,
  input  logic             call_done,
  input  logic [RES_W-1:0] call_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_result,
  output logic             out_timeout,
  output logic             busy,
  output logic [7:0]       call_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ARG_W-1:0]   mem_q [DEPTH];
  logic [ARG_W-1:0]   mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               call_start_q, call_start_d;
  logic [ARG_W-1:0]   call_arg_q, call_arg_d;
  logic               done_q, done_d;
  logic [15:0]        tmo_cnt_q, tmo_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [RES_W-1:0]   out_result_q, out_result_d;
  logic               out_timeout_q, out_timeout_d;
  logic [7:0]         call_count_q, call_count_d;

  logic full, empty, push, launch, done_evt;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == {(AW + 1){1'b0}});
  assign push     = in_valid && !full;
  // A launch needs the result slot free now or freed by this cycle's handshake.
  assign launch   = (state_q == S_IDLE) && !empty && (!out_valid_q || out_ready);
  assign done_evt = call_done && !done_q;

  // Argument FIFO bookkeeping; the head is popped only by a launch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_arg;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (launch) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, launch})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Call FSM and result register next-state logic.
  always_comb begin
    state_d       = state_q;
    call_start_d  = 1'b0;
    call_arg_d    = call_arg_q;
    done_d        = call_done;
    tmo_cnt_d     = tmo_cnt_q;
    out_valid_d   = out_valid_q && !out_ready;
    out_result_d  = out_result_q;
    out_timeout_d = out_timeout_q;
    call_count_d  = call_count_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d      = S_START;
          call_start_d = 1'b1;
          call_arg_d   = mem_q[rd_ptr_q];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d   = S_WAIT;
        tmo_cnt_d = 16'd0;
      end
      S_WAIT: begin
        // A done edge in the same cycle as the timeout still counts as a real result.
        if (done_evt) begin
          state_d       = S_IDLE;
          out_valid_d   = 1'b1;
          out_result_d  = call_result;
          out_timeout_d = 1'b0;
          call_count_d  = call_count_q + 8'd1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d       = S_IDLE;
          out_valid_d   = 1'b1;
          out_result_d  = {RES_W{1'b0}};
          out_timeout_d = 1'b1;
          call_count_d  = call_count_q + 8'd1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ARG_W{1'b0}};
      end
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      count_q       <= {(AW + 1){1'b0}};
      call_start_q  <= 1'b0;
      call_arg_q    <= {ARG_W{1'b0}};
      done_q        <= 1'b0;
      tmo_cnt_q     <= 16'd0;
      out_valid_q   <= 1'b0;
      out_result_q  <= {RES_W{1'b0}};
      out_timeout_q <= 1'b0;
      call_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      call_start_q  <= call_start_d;
      call_arg_q    <= call_arg_d;
      done_q        <= done_d;
      tmo_cnt_q     <= tmo_cnt_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_timeout_q <= out_timeout_d;
      call_count_q  <= call_count_d;
    end
  end

  assign in_ready    = !full;
  assign call_start  = call_start_q;
  assign call_arg    = call_arg_q;
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_timeout = out_timeout_q;
  assign call_count  = call_count_q;
  assign busy        = (state_q != S_IDLE) || !empty || out_valid_q;

endmodule

// File: tb/tb_hls_call_sequencer.sv
// Directed bench for hls_call_sequencer with a small callee model (done rises
// about 3 cycles after call_start; result 2 for arg 1, 1 for arg 0).
module tb_hls_call_sequencer;

  logic       clk, rst;
  logic       in_valid, in_ready, in_arg;
  logic       call_start, call_arg, call_done;
  logic [1:0] call_result;
  logic       out_valid, out_ready, out_timeout, busy;
  logic [1:0] out_result;
  logic [7:0] call_count;

  logic       model_done, model_stall, tb_done, marg;
  logic [1:0] model_res;
  int         mcnt;
  int         total, bad, starts, cyc;
  int         start_cyc[$];

  assign call_done   = model_done | tb_done;
  assign call_result = model_res;

  hls_call_sequencer #(.ARG_W(1), .RES_W(2), .DEPTH(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_arg(in_arg),
    .call_start(call_start), .call_arg(call_arg),
    .call_done(call_done), .call_result(call_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_timeout(out_timeout),
    .busy(busy), .call_count(call_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Records every cycle in which call_start is high.
  initial begin
    starts = 0;
    forever begin
      @(negedge clk);
      if (call_start) begin
        starts++;
        start_cyc.push_back(cyc);
      end
    end
  end

  // Callee model: done held from the previous call drops 2 cycles after start, rises after 3.
  initial begin
    model_done = 1'b0;
    model_res  = 2'd0;
    marg       = 1'b0;
    mcnt       = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        model_done = 1'b0;
        mcnt       = 0;
      end else if (call_start) begin
        mcnt = 3;
        marg = call_arg;
      end else if (mcnt != 0) begin
        mcnt = mcnt - 1;
        if (mcnt == 1) begin
          model_done = 1'b0;
        end else if (mcnt == 0 && !model_stall) begin
          model_done = 1'b1;
          model_res  = marg ? 2'd2 : 2'd1;
        end
      end
    end
  end

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset;
    in_valid    = 1'b0;
    in_arg      = 1'b0;
    out_ready   = 1'b0;
    tb_done     = 1'b0;
    model_stall = 1'b0;
    step;
    rst = 1'b1;
    step;
    step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_reset;
    logic [15:0] got;
    apply_reset;
    got = {in_ready, call_start, call_arg, out_valid, out_result, out_timeout, busy, call_count};
    total++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL reset_vals got=%h exp=%h", got, {1'b1, 15'd0});
      bad++;
    end
  endtask

  task automatic test_single_call;
    int s0;
    logic [11:0] got;
    apply_reset;
    s0 = starts;
    in_arg = 1'b1; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    total++;
    if (call_start !== 1'b0) begin $display("FAIL start_early got=%b exp=0", call_start); bad++; end
    step;
    total++;
    if ({call_start, call_arg} !== 2'b11) begin
      $display("FAIL start_pulse got=%b exp=11", {call_start, call_arg}); bad++;
    end
    step;
    total++;
    if ({call_start, busy} !== 2'b01) begin
      $display("FAIL start_one_cycle got=%b exp=01", {call_start, busy}); bad++;
    end
    step;
    step;
    total++;
    if (out_valid !== 1'b0) begin $display("FAIL result_early got=%b exp=0", out_valid); bad++; end
    step;
    got = {out_valid, out_result, out_timeout, call_count};
    total++;
    if (got !== {1'b1, 2'd2, 1'b0, 8'd1}) begin
      $display("FAIL single_result got=%h exp=%h", got, {1'b1, 2'd2, 1'b0, 8'd1}); bad++;
    end
    total++;
    if (starts - s0 !== 1) begin $display("FAIL single_starts got=%0d exp=1", starts - s0); bad++; end
  endtask

  task automatic test_back_to_back;
    int n0, nres, gap;
    logic [1:0] res [2];
    apply_reset;
    out_ready = 1'b1;
    n0 = start_cyc.size();
    nres = 0;
    res[0] = 2'd0; res[1] = 2'd0;
    in_arg = 1'b1; in_valid = 1'b1;
    step;
    in_arg = 1'b0;
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 20 && nres < 2; i++) begin
      if (out_valid) begin
        res[nres] = out_result;
        nres++;
      end
      step;
    end
    total++;
    if (nres != 2) begin $display("FAIL b2b_count got=%0d exp=2", nres); bad++; end
    total++;
    if ({res[0], res[1]} !== {2'd2, 2'd1}) begin
      $display("FAIL b2b_order got=%0d,%0d exp=2,1", res[0], res[1]); bad++;
    end
    total++;
    if (call_count !== 8'd2) begin $display("FAIL b2b_call_count got=%0d exp=2", call_count); bad++; end
    total++;
    if (start_cyc.size() - n0 != 2) begin
      $display("FAIL b2b_starts got=%0d exp=2", start_cyc.size() - n0); bad++;
    end else begin
      gap = start_cyc[n0 + 1] - start_cyc[n0];
      total++;
      if (gap != 5) begin $display("FAIL b2b_gap got=%0d exp=5", gap); bad++; end
    end
  endtask

  task automatic test_fifo_full;
    int s0, acc;
    apply_reset;
    model_stall = 1'b1;
    s0 = starts;
    acc = 0;
    in_arg = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (in_ready) acc++;
      step;
    end
    total++;
    if (acc != 5) begin $display("FAIL full_accepted got=%0d exp=5", acc); bad++; end
    total++;
    if ({in_ready, out_valid, out_timeout} !== 3'b011) begin
      $display("FAIL full_held got=%b exp=011", {in_ready, out_valid, out_timeout}); bad++;
    end
    total++;
    if (starts - s0 !== 1) begin $display("FAIL full_starts got=%0d exp=1", starts - s0); bad++; end
    out_ready = 1'b1;
    step;
    total++;
    if ({in_ready, call_start} !== 2'b11) begin
      $display("FAIL full_pop got=%b exp=11", {in_ready, call_start}); bad++;
    end
    step;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin $display("FAIL full_refill got=%b exp=0", in_ready); bad++; end
  endtask

  task automatic test_hold_output;
    int s0;
    apply_reset;
    s0 = starts;
    in_arg = 1'b1; in_valid = 1'b1;
    step;
    in_arg = 1'b0;
    step;
    in_valid = 1'b0;
    repeat (4) step;
    total++;
    if ({out_valid, out_result} !== 3'b110) begin
      $display("FAIL hold_first got=%b exp=110", {out_valid, out_result}); bad++;
    end
    for (int i = 0; i < 10; i++) begin
      step;
      total++;
      if ({out_valid, out_result} !== 3'b110 || starts - s0 != 1) begin
        $display("FAIL hold_stable cyc=%0d got=%b starts=%0d exp=110 starts=1",
                 i, {out_valid, out_result}, starts - s0);
        bad++;
      end
    end
    out_ready = 1'b1;
    step;
    total++;
    if ({call_start, call_arg} !== 2'b10) begin
      $display("FAIL hold_release got=%b exp=10", {call_start, call_arg}); bad++;
    end
    for (int i = 0; i < 10 && !out_valid; i++) step;
    total++;
    if ({out_valid, out_result, call_count} !== {1'b1, 2'd1, 8'd2}) begin
      $display("FAIL hold_second got=%h exp=%h", {out_valid, out_result, call_count},
               {1'b1, 2'd1, 8'd2});
      bad++;
    end
  endtask

  task automatic test_timeout;
    int s0;
    apply_reset;
    model_stall = 1'b1;
    s0 = starts;
    in_arg = 1'b1; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (9) step;
    total++;
    if (out_valid !== 1'b0) begin $display("FAIL tmo_early got=%b exp=0", out_valid); bad++; end
    step;
    total++;
    if ({out_valid, out_timeout, out_result, call_count} !== {1'b1, 1'b1, 2'd0, 8'd1}) begin
      $display("FAIL tmo_result got=%h exp=%h", {out_valid, out_timeout, out_result, call_count},
               {1'b1, 1'b1, 2'd0, 8'd1});
      bad++;
    end
    step;
    step;
    tb_done = 1'b1;
    repeat (4) step;
    total++;
    if ({out_valid, out_timeout, call_count} !== {1'b1, 1'b1, 8'd1} || starts - s0 != 1) begin
      $display("FAIL tmo_late_done got=%h starts=%0d exp=%h starts=1",
               {out_valid, out_timeout, call_count}, starts - s0, {1'b1, 1'b1, 8'd1});
      bad++;
    end
    tb_done = 1'b0;
  endtask

  task automatic test_reset_mid_wait;
    int s0;
    logic [15:0] got;
    apply_reset;
    out_ready = 1'b1;
    in_arg = 1'b1; in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) step;
    step;
    model_stall = 1'b1;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (3) step;
    total++;
    if ({busy, call_arg, call_count} !== {1'b1, 1'b1, 8'd1}) begin
      $display("FAIL rst_pre got=%h exp=%h", {busy, call_arg, call_count}, {1'b1, 1'b1, 8'd1});
      bad++;
    end
    #2;
    rst = 1'b1;
    #1;
    got = {in_ready, call_start, call_arg, out_valid, out_result, out_timeout, busy, call_count};
    total++;
    if (got !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL rst_async got=%h exp=%h", got, {1'b1, 15'd0}); bad++;
    end
    step;
    step;
    rst = 1'b0;
    model_stall = 1'b0;
    s0 = starts;
    repeat (4) step;
    total++;
    if (busy !== 1'b0 || starts != s0) begin
      $display("FAIL rst_idle got busy=%b starts=%0d exp busy=0 starts=0", busy, starts - s0); bad++;
    end
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 12 && !out_valid; i++) step;
    total++;
    if ({out_valid, out_result, out_timeout, call_count} !== {1'b1, 2'd2, 1'b0, 8'd1}) begin
      $display("FAIL rst_after got=%h exp=%h", {out_valid, out_result, out_timeout, call_count},
               {1'b1, 2'd2, 1'b0, 8'd1});
      bad++;
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_arg      = 1'b0;
    out_ready   = 1'b0;
    tb_done     = 1'b0;
    model_stall = 1'b0;
    test_reset;
    test_single_call;
    test_back_to_back;
    test_fifo_full;
    test_hold_output;
    test_timeout;
    test_reset_mid_wait;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hls_call_sequencer.md
# hls_call_sequencer

Upstream/downstream harness for a synthesized HLS `main` callee. It queues argument words, issues one call at a time on the callee's start/done handshake (`r_enable` / `w_enable`), and returns each `result` with a timeout flag on a ready/valid output. It replaces ad-hoc testbench pulsing so that many callee invocations can run back-to-back in hardware.

## Interface
- ARG_W, 1, width of callee argument (`init_i`)
- RES_W, 2, width of callee `result`
- DEPTH, 4, argument FIFO entries (power of two, ≥2)
- TIMEOUT, 255, max cycles in WAIT before forced completion (1..2^16-1)

- clk  in  1  clock; all state on posedge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  argument offered
- in_ready  out  1  FIFO not full
- in_arg  in  ARG_W  argument word
- call_start  out  1  to callee `r_enable`
- call_arg  out  ARG_W  to callee `init_i`; held stable from START through WAIT
- call_done  in  1  from callee `w_enable` (level; may stay high)
- call_result  in  RES_W  from callee `result`; valid while `call_done` high
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_result  out  RES_W  captured result (0 on timeout)
- out_timeout  out  1  1 if this entry ended by timeout
- busy  out  1  state ≠ IDLE or FIFO non-empty or out_valid
- call_count  out  8  completed calls (normal + timeout), wraps 255→0

## Operation
- FIFO: push on `in_valid && in_ready`; `in_ready = !full`, no pass-through when full. Pop only on IDLE→START.
- Output register: single entry. Freed on `out_valid && out_ready`.
- FSM states IDLE, START, WAIT:
  - IDLE→START when FIFO non-empty and (`!out_valid` or `out_ready` this cycle); head popped into `call_arg`.
  - START: `call_start`=1 for exactly this one cycle; → WAIT; timeout counter cleared; `done_q` reloaded with current `call_done`.
  - WAIT: done event = `call_done && !done_q` (rising edge; `done_q` = `call_done` of the previous cycle). On a done event, capture `call_result`, `out_timeout`=0, set `out_valid`, increment `call_count`, → IDLE.
  - WAIT: if the counter reaches TIMEOUT with no done event, `out_result`=0, `out_timeout`=1, set `out_valid`, increment `call_count`, → IDLE. A late done edge from the abandoned call is ignored, because it is only sampled in WAIT.
  - Done event and timeout in the same cycle: done wins (`out_timeout`=0).
- `call_arg` keeps its last value in IDLE.

## Timing
- Reset values: `in_ready`=1, `call_start`=0, `call_arg`=0, `out_valid`=0, `out_result`=0, `out_timeout`=0, `busy`=0, `call_count`=0, FIFO empty, state IDLE. Outputs clear immediately on `rst` rising, without waiting for a clock edge.
- Push at edge k into an empty FIFO, IDLE, output free: START at k+1 (`call_start` high k+1..k+2), WAIT from k+2.
- `call_done` first sampled high at edge d (in WAIT): `out_valid`=1 after edge d, i.e. one cycle of latency. If the output is free or being consumed, IDLE→START at d+1, so the gap between consecutive `call_start` pulses is at least 2 cycles.
- `out_valid` stays high with `out_result` stable until `out_ready`. No new START may occur while the output register is held and not consumed.
- Reset asserted mid-WAIT: the call is abandoned and FIFO contents are lost. After deassertion the block is idle until new pushes arrive.

## Test plan
- Callee model returns 2 for arg 1, with `call_done` rising 3 cycles after `call_start` -> exactly one 1-cycle `call_start` with `call_arg`=1; `out_result`=2, `out_timeout`=0, `call_count`=1.
- Push args 1,0 on back-to-back cycles; model returns {2,1}, `out_ready`=1 -> outputs 2 then 1 in order; `call_start` pulses ≥2 cycles apart; `call_done` held high between calls does not create a false completion.
- Model stalled, DEPTH=4: push 6 args -> `in_ready` drops after 5 accepted (4 in FIFO + 1 in flight); 6th is held until a pop occurs.
- `out_ready`=0 for 10 cycles after the first result -> `out_valid`/`out_result` remain stable; no second `call_start` until `out_ready`=1.
- TIMEOUT=8, model never asserts done -> `out_valid` with `out_timeout`=1, `out_result`=0 after 8 WAIT cycles; a done edge arriving 2 cycles later is ignored and `call_count`=1.
- Assert `rst` mid-WAIT between clock edges -> all outputs reach their reset values before the next edge; after release, one push produces a normal call with `call_count`=1.
